syn_fft_but_pipe: RTL and testbench

Parametrised, pipelined radix-2 DIT complex butterfly for the synesthesia FFT engine. It is the successor to the single-result butterfly.
- Computes both outputs per issue: X = A + W·B and Y = A − W·B.
- Adds forward/inverse mode, optional per-stage ÷2 scaling, rounding, saturation and an output FIFO with sticky overflow/underflow flags.
- Sits between the FFT sequencer (sample fetch) and the result write-back logic.

---
 rtl/syn_fft_pkg.sv | 44 ++++
 rtl/syn_but_fifo.sv | 58 +++++
 rtl/syn_fft_but_pipe.sv | 137 +++++++++++++
 tb/tb_syn_fft_but_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/syn_fft_pkg.sv
// Shared types, constants and the round/saturate helper for the FFT datapath.
package syn_fft_pkg;

  localparam int FFT_BUT_LAT = 3;
  localparam int FFT_DATA_W  = 16;
  localparam int FFT_TWDL_W  = 16;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } fft_cplx_t;

  typedef struct packed {
    logic signed [FFT_TWDL_W-1:0] re;
    logic signed [FFT_TWDL_W-1:0] im;
  } fft_twdl_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sat_rnd_t;

  // Optional /2 with round-half-up, then clamp to a signed out_w range.
  function automatic sat_rnd_t sat_rnd(input logic signed [63:0] v,
                                       input logic halve,
                                       input int out_w);
    sat_rnd_t r;
    logic signed [63:0] t, hi, lo;
    t  = halve ? ((v + 64'sd1) >>> 1) : v;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sat = 1'b0;
    r.val = t;
    if (t > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (t < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/syn_but_fifo.sv
// First-word-fall-through FIFO; head holds its last value when the FIFO drains.
module syn_but_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     ovf,
  output logic                     unf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             full, pop, push;

  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  assign pop     = rd_en & ~empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign push    = wr_en & (~full | pop);
  assign ovf     = wr_en & full & ~pop;
  assign unf     = rd_en & empty;
  assign rd_data = empty ? hold_q : mem[rd_ptr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      hold_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/syn_fft_but_pipe.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B, into an output FIFO.
module syn_fft_but_pipe import syn_fft_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int TWDL_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SCALE_EN   = 1
) (
  input  logic                          clk_ir,
  input  logic                          rst_il,
  input  logic [2*DATA_W-1:0]           sample_a_i,
  input  logic [2*DATA_W-1:0]           sample_b_i,
  input  logic [2*TWDL_W-1:0]           twdl_i,
  input  logic                          sample_rdy_i,
  input  logic                          inv_mode_i,
  input  logic                          scale_i,
  output logic [2*DATA_W-1:0]           res_x_o,
  output logic [2*DATA_W-1:0]           res_y_o,
  output logic                          res_rdy_o,
  input  logic                          res_ack_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_occ_o,
  output logic                          sat_flag_o,
  output logic                          bffr_ovrflw_o,
  output logic                          bffr_underflw_o,
  input  logic                          clr_flags_i
);

  localparam int STAGES = FFT_BUT_LAT;
  localparam int PW     = DATA_W + TWDL_W;
  localparam int SW     = PW + 1;
  localparam int RW     = DATA_W + 2;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;
  typedef struct packed {
    logic signed [TWDL_W-1:0] re;
    logic signed [TWDL_W-1:0] im;
  } twdl_t;
  typedef logic signed [PW-1:0] pw_t;
  typedef logic signed [SW-1:0] sw_t;
  typedef logic signed [RW-1:0] rw_t;

  localparam sw_t RND = sw_t'(1) <<< (TWDL_W - 2);

  logic [STAGES:1] vld_pipe;
  cplx_t a1, b1, a2, a3;
  twdl_t w1;
  logic  sc1, sc2, sc3;
  pw_t   p_rr, p_ii, p_ri, p_ir;
  rw_t   p3_re, p3_im, pre_rnd, pim_rnd;
  sw_t   pre_sum, pim_sum;
  sat_rnd_t xr_s, xi_s, yr_s, yi_s;
  cplx_t x_res, y_res;
  logic  sat_evt, fifo_empty, fifo_ovf, fifo_unf;

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) vld_pipe <= '0;
    else         vld_pipe <= {vld_pipe[STAGES-1:1], sample_rdy_i};
  end

  // Data registers load only with their stage valid, so idle-cycle input churn is ignored.
  always_ff @(posedge clk_ir) begin
    if (sample_rdy_i) begin
      a1    <= sample_a_i;
      b1    <= sample_b_i;
      w1.re <= twdl_i[2*TWDL_W-1:TWDL_W];
      w1.im <= inv_mode_i ? -twdl_i[TWDL_W-1:0] : twdl_i[TWDL_W-1:0];
      sc1   <= scale_i & (SCALE_EN != 0);
    end
    if (vld_pipe[1]) begin
      a2   <= a1;
      sc2  <= sc1;
      p_rr <= pw_t'(b1.re) * pw_t'(w1.re);
      p_ii <= pw_t'(b1.im) * pw_t'(w1.im);
      p_ri <= pw_t'(b1.re) * pw_t'(w1.im);
      p_ir <= pw_t'(b1.im) * pw_t'(w1.re);
    end
    if (vld_pipe[2]) begin
      a3    <= a2;
      sc3   <= sc2;
      p3_re <= pre_rnd;
      p3_im <= pim_rnd;
    end
  end

  always_comb begin
    pre_sum = sw_t'(p_rr) - sw_t'(p_ii) + RND;
    pim_sum = sw_t'(p_ri) + sw_t'(p_ir) + RND;
    pre_rnd = rw_t'(pre_sum >>> (TWDL_W - 1));
    pim_rnd = rw_t'(pim_sum >>> (TWDL_W - 1));
  end

  always_comb begin
    xr_s     = sat_rnd(64'(a3.re) + 64'(p3_re), sc3, DATA_W);
    xi_s     = sat_rnd(64'(a3.im) + 64'(p3_im), sc3, DATA_W);
    yr_s     = sat_rnd(64'(a3.re) - 64'(p3_re), sc3, DATA_W);
    yi_s     = sat_rnd(64'(a3.im) - 64'(p3_im), sc3, DATA_W);
    x_res.re = DATA_W'(xr_s.val);
    x_res.im = DATA_W'(xi_s.val);
    y_res.re = DATA_W'(yr_s.val);
    y_res.im = DATA_W'(yi_s.val);
    sat_evt  = vld_pipe[STAGES] & (xr_s.sat | xi_s.sat | yr_s.sat | yi_s.sat);
  end

  syn_but_fifo #(
    .WIDTH (4*DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gclk    (clk_ir),
    .grst_n  (rst_il),
    .wr_en   (vld_pipe[STAGES]),
    .wr_data ({x_res, y_res}),
    .rd_en   (res_ack_i),
    .rd_data ({res_x_o, res_y_o}),
    .empty   (fifo_empty),
    .occ     (fifo_occ_o),
    .ovf     (fifo_ovf),
    .unf     (fifo_unf)
  );

  assign res_rdy_o = ~fifo_empty;

  // A new event in the clear cycle wins.
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      sat_flag_o      <= 1'b0;
      bffr_ovrflw_o   <= 1'b0;
      bffr_underflw_o <= 1'b0;
    end else begin
      sat_flag_o      <= (sat_flag_o & ~clr_flags_i) | sat_evt;
      bffr_ovrflw_o   <= (bffr_ovrflw_o & ~clr_flags_i) | fifo_ovf;
      bffr_underflw_o <= (bffr_underflw_o & ~clr_flags_i) | fifo_unf;
    end
  end

endmodule

// File: tb/tb_syn_fft_but_pipe.sv
// Scoreboard bench for the pipelined butterfly: directed vectors, decoupled pop monitor.
module tb_syn_fft_but_pipe;

  logic        clk_ir = 1'b0;
  logic        rst_il;
  logic [31:0] sample_a_i, sample_b_i, twdl_i;
  logic        sample_rdy_i, inv_mode_i, scale_i;
  logic [31:0] res_x_o, res_y_o;
  logic        res_rdy_o;
  logic        res_ack_i;
  logic [3:0]  fifo_occ_o;
  logic        sat_flag_o, bffr_ovrflw_o, bffr_underflw_o;
  logic        clr_flags_i;

  syn_fft_but_pipe #(
    .DATA_W(16), .TWDL_W(16), .FIFO_DEPTH(8), .SCALE_EN(1)
  ) dut (
    .clk_ir          (clk_ir),
    .rst_il          (rst_il),
    .sample_a_i      (sample_a_i),
    .sample_b_i      (sample_b_i),
    .twdl_i          (twdl_i),
    .sample_rdy_i    (sample_rdy_i),
    .inv_mode_i      (inv_mode_i),
    .scale_i         (scale_i),
    .res_x_o         (res_x_o),
    .res_y_o         (res_y_o),
    .res_rdy_o       (res_rdy_o),
    .res_ack_i       (res_ack_i),
    .fifo_occ_o      (fifo_occ_o),
    .sat_flag_o      (sat_flag_o),
    .bffr_ovrflw_o   (bffr_ovrflw_o),
    .bffr_underflw_o (bffr_underflw_o),
    .clr_flags_i     (clr_flags_i)
  );

  always #5 clk_ir = ~clk_ir;

  typedef struct { logic [31:0] x; logic [31:0] y; } exp_t;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   auto_pop = 1'b0;
  bit   force_ack = 1'b0;

  function automatic logic [31:0] cp(input int re, input int im);
    logic [15:0] r, i;
    r = re[15:0];
    i = im[15:0];
    return {r, i};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one strobe; expected result goes to the scoreboard only if it should survive.
  task automatic issue(input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi, input bit inv, input bit sc,
                       input int xr, input int xi, input int yr, input int yi,
                       input bit keep);
    exp_t e;
    sample_a_i   = cp(ar, ai);
    sample_b_i   = cp(br, bi);
    twdl_i       = cp(wr, wi);
    inv_mode_i   = inv;
    scale_i      = sc;
    sample_rdy_i = 1'b1;
    if (keep) begin
      e.x = cp(xr, xi);
      e.y = cp(yr, yi);
      sb.push_back(e);
    end
    @(posedge clk_ir); #1;
    sample_rdy_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_ir);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || res_rdy_o) && k < 100) begin
      @(posedge clk_ir); #1;
      k++;
    end
    chk("drain_done", 32'(k < 100), 32'd1);
  endtask

  task automatic clr_pulse();
    clr_flags_i = 1'b1;
    @(posedge clk_ir); #1;
    clr_flags_i = 1'b0;
  endtask

  // Monitor: decides the pop, compares the head against the scoreboard.
  initial begin
    exp_t e;
    bit   want;
    res_ack_i = 1'b0;
    forever begin
      @(negedge clk_ir);
      want = force_ack || (auto_pop && res_rdy_o);
      if (want && res_rdy_o) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL pop_unexpected: got x=%h y=%h, expected nothing", res_x_o, res_y_o);
        end else begin
          e = sb.pop_front();
          if (res_x_o !== e.x || res_y_o !== e.y) begin
            n_bad++;
            $display("FAIL pop_data: got x=%h y=%h, expected x=%h y=%h",
                     res_x_o, res_y_o, e.x, e.y);
          end
        end
      end
      res_ack_i = want;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_il = 1'b0;
    sample_a_i = '0; sample_b_i = '0; twdl_i = '0;
    sample_rdy_i = 1'b0; inv_mode_i = 1'b0; scale_i = 1'b0; clr_flags_i = 1'b0;
    cycles(3);
    chk("rst_rdy", 32'(res_rdy_o), 32'd0);
    chk("rst_occ", 32'(fifo_occ_o), 32'd0);
    chk("rst_x", res_x_o, 32'd0);
    chk("rst_flags", {29'd0, sat_flag_o, bffr_ovrflw_o, bffr_underflw_o}, 32'd0);
    rst_il = 1'b1;
    cycles(2);

    // Basic vector and latency: strobe sampled at edge E1, visible after E4.
    auto_pop = 1'b1;
    issue(1000, 0, 200, -100, 16'h4000, 0, 0, 0, 1100, -50, 900, 50, 1);
    @(posedge clk_ir); @(posedge clk_ir); #1;
    chk("lat_not_yet", 32'(res_rdy_o), 32'd0);
    @(posedge clk_ir); #1;
    chk("lat_rdy", 32'(res_rdy_o), 32'd1);
    chk("lat_occ", 32'(fifo_occ_o), 32'd1);
    drain();

    // Imaginary twiddle, forward then inverse back-to-back.
    issue(1000, 0, 200, -100, 0, 16'h4000, 0, 0, 1050, 100, 950, -100, 1);
    issue(1000, 0, 200, -100, 0, 16'h4000, 1, 0, 950, -100, 1050, 100, 1);
    drain();
    chk("no_sat_yet", 32'(sat_flag_o), 32'd0);

    // Saturation, then scaled version of the same operands.
    issue(32000, 0, 32000, 0, 16'h4000, 0, 0, 0, 32767, 0, 16000, 0, 1);
    drain();
    chk("sat_set", 32'(sat_flag_o), 32'd1);
    clr_pulse();
    chk("sat_clr", 32'(sat_flag_o), 32'd0);
    issue(32000, 0, 32000, 0, 16'h4000, 0, 0, 1, 24000, 0, 8000, 0, 1);
    drain();
    chk("sat_scaled", 32'(sat_flag_o), 32'd0);

    // Ten back-to-back strobes into an eight-deep FIFO with no pops.
    auto_pop = 1'b0;
    for (int i = 0; i < 10; i++)
      issue(100*i, 0, 200, -100, 16'h4000, 0, 0, 0,
            100*i + 100, -50, 100*i - 100, 50, i < 8);
    cycles(5);
    chk("full_occ", 32'(fifo_occ_o), 32'd8);
    chk("ovf_set", 32'(bffr_ovrflw_o), 32'd1);
    chk("full_rdy", 32'(res_rdy_o), 32'd1);
    clr_pulse();
    chk("ovf_clr", 32'(bffr_ovrflw_o), 32'd0);

    // Pop and write in the same cycle while full.
    issue(5000, 0, 200, -100, 16'h4000, 0, 0, 0, 5100, -50, 4900, 50, 1);
    @(posedge clk_ir); @(posedge clk_ir); #1;
    force_ack = 1'b1;
    @(posedge clk_ir); #1;
    force_ack = 1'b0;
    chk("popwr_occ", 32'(fifo_occ_o), 32'd8);
    chk("popwr_ovf", 32'(bffr_ovrflw_o), 32'd0);
    auto_pop = 1'b1;
    drain();

    // Pop while empty.
    auto_pop = 1'b0;
    cycles(2);
    force_ack = 1'b1;
    @(posedge clk_ir); #1;
    force_ack = 1'b0;
    chk("unf_set", 32'(bffr_underflw_o), 32'd1);
    chk("unf_occ", 32'(fifo_occ_o), 32'd0);

    // Reset with one entry stored (saturating) and three still in flight.
    issue(32000, 0, 32000, 0, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 200, -100, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(2, 0, 200, -100, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(3, 0, 200, -100, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_occ", 32'(fifo_occ_o), 32'd1);
    #1 rst_il = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(res_rdy_o), 32'd0);
    chk("mid_rst_occ", 32'(fifo_occ_o), 32'd0);
    chk("mid_rst_flags", {29'd0, sat_flag_o, bffr_ovrflw_o, bffr_underflw_o}, 32'd0);
    chk("mid_rst_x", res_x_o, 32'd0);
    cycles(2);
    rst_il = 1'b1;
    cycles(8);
    chk("post_rst_occ", 32'(fifo_occ_o), 32'd0);
    chk("post_rst_rdy", 32'(res_rdy_o), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
